sync_mem_ctrl: RTL
==================

# sync_mem_ctrl

Parametrised successor to the single-port data memory: a word-addressed, single-ported synchronous RAM behind a valid/ready request port and a registered one-cycle response pulse. It adds four things: configurable width and depth, per-byte write enables, programmable read latency (wait states) and an error response for out-of-range addresses. It sits between the core's MEM stage and the storage array; one request is outstanding at a time.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 32, request address width (word address)
- DEPTH, 1024, words of storage; power of two; IDX_W = log2(DEPTH)
- LATENCY, 1, read latency in cycles, 1..8

- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte-lane write enables (bit i → bits 8i+7:8i)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address out of range; qualified by rsp_valid

## Operation
- Accept = req_valid & req_ready at a posedge (edge T).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
  - Accepted write → RESP.
  - Accepted read, LATENCY=1 → RESP.
  - Accepted read, LATENCY>1 → WAIT, with the wait counter loaded to LATENCY-2.
  - WAIT: req_ready=0; the counter decrements each cycle; at 0 → RESP.
  - RESP: rsp_valid=1 and req_ready=1. An accept here branches exactly as from IDLE (back-to-back). With no accept → IDLE.
- Range check: out of range when req_addr[ADDR_W-1:IDX_W] != 0.
- Write: at edge T, each lane with req_be set is written into word req_addr[IDX_W-1:0]; other lanes are unchanged. req_be=0 is a no-op but is still acknowledged. An out-of-range write is suppressed.
- Read: the array word is sampled at edge T into a hold register. rsp_rdata presents it during RESP. req_be is ignored.
- Error response: rsp_err=1 and rsp_rdata=0 during RESP.
- Output rules: rsp_rdata and rsp_err are registered. They are 0 whenever rsp_valid=0.
- Storage is not cleared by reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
- Write accepted at edge T: rsp_valid is high in the cycle after edge T. Write latency is always 1.
- Read accepted at edge T: rsp_valid is high in the cycle after edge T+LATENCY-1.
- Throughput: one write per cycle; one read per LATENCY cycles.
- Read-after-write: a read accepted in a write's RESP cycle returns the new data, because the write committed at the earlier edge.
- Reset asserted mid-operation: the in-flight response is dropped and no rsp_valid is produced. A write already committed at its accept edge remains in storage.
- req_* inputs are don't-care when req_valid=0. Inputs offered while req_ready=0 are ignored and must be held by the requester.

## Configuration
- MEM_RANGE_CHECK_EN defined: the range check above applies; rsp_err is live; out-of-range writes are suppressed.
- Not defined: the upper address bits are ignored, so accesses alias modulo DEPTH; rsp_err is tied 0; there is no comparator logic.

## Structure
- Package mem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - LAT_MAX=8 and the counter width;
  - an elaboration check for LATENCY in 1..LAT_MAX, DATA_W%8==0 and DEPTH a power of two.
- Sub-module mem_array contains:
  - DEPTH×DATA_W storage;
  - byte-lane write on posedge;
  - synchronous read into the hold register.
- The controller FSM, counter and range check live in sync_mem_ctrl.

## Test plan
- Reset deasserted, no requests → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 indefinitely.
- Write addr 5 data 0xDEADBEEF be=4'b1111, then read addr 5 with LATENCY=3 → the write ack arrives 1 cycle after accept; the read's rsp_valid comes 3 cycles after accept with rsp_rdata=0xDEADBEEF; req_ready=0 during WAIT.
- Write addr 7 with 0x11223344 and be=1111, then 0xAABBCCDD with be=0101, then read addr 7 → rdata=0x11BB33DD.
- With MEM_RANGE_CHECK_EN, DEPTH=1024: write addr 0x400 data 0x1, then read addr 0x400 → both responses have rsp_err=1 and rdata=0; a read of addr 0 is unchanged. Without the macro, the read returns 0x1 and rsp_err=0.
- Back-to-back writes on addrs 0..3 with req_valid held high, LATENCY=1 → one ack per cycle; subsequent reads return the written values.
- Read accepted with LATENCY=4, reset pulsed low for 1 cycle during WAIT → no rsp_valid; state returns to IDLE; req_ready=1 after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and configuration limits for the sync_mem_ctrl memory block.
// Provides the controller state enum, the wait-counter sizing and the legality check.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int unsigned LAT_MAX = 8;
   // The counter only ever holds LATENCY-2, so LAT_MAX-2 is its largest value.
   localparam int unsigned CNT_W   = $clog2(LAT_MAX - 1);

   function automatic bit cfg_ok(input int unsigned latency,
                                 input int unsigned data_w,
                                 input int unsigned depth);
      return (latency >= 1) && (latency <= LAT_MAX) &&
             (data_w != 0) && ((data_w % 8) == 0) &&
             (depth != 0) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-ported DEPTH x DATA_W storage with byte-lane writes and a synchronous
// read into a hold register; the hold register is zeroed for non-read accesses.
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  rd_en,
   input  logic                  rd_zero,
   output logic [DATA_W-1:0]     hold
);

   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto RAM macros; its
   // contents stay undefined until written and survive a controller reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // NOTE: sequential state is always updated with non-blocking assignments so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold <= '0;
      end else if (rd_en) begin
         hold <= rd_zero ? '0 : mem[idx];
      end
   end

endmodule

// File: rtl/sync_mem_ctrl.sv
// Request/response controller in front of mem_array: FSM, read wait states and
// address range check. Define MEM_RANGE_CHECK_EN to flag out-of-range accesses.
module sync_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDX_W = $clog2(DEPTH);

   if (!cfg_ok(LATENCY, DATA_W, DEPTH)) begin : g_cfg_err
      $error("sync_mem_ctrl: LATENCY must be 1..%0d, DATA_W a multiple of 8, DEPTH a power of two",
             LAT_MAX);
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             in_range;
   logic [DATA_W-1:0] hold;

   assign req_ready = (state_q != WAIT);
   assign accept    = req_valid & req_ready;

`ifdef MEM_RANGE_CHECK_EN
   logic err_q;

   assign in_range = (req_addr[ADDR_W-1:IDX_W] == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= ~in_range;
      end
   end

   assign rsp_err = rsp_valid & err_q;
`else
   // Upper address bits are deliberately dropped: accesses alias modulo DEPTH.
   logic unused_upper_addr;

   assign unused_upper_addr = ^req_addr[ADDR_W-1:IDX_W];
   assign in_range          = 1'b1;
   assign rsp_err           = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, otherwise paths
   // that skip an assignment would infer latches.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               if (req_wen || (LATENCY == 1)) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 2);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (accept & req_wen & in_range),
      .be      (req_be),
      .idx     (req_addr[IDX_W-1:0]),
      .wdata   (req_wdata),
      .rd_en   (accept),
      .rd_zero (req_wen | ~in_range),
      .hold    (hold)
   );

   // The hold register already carries read data from the accept edge; it is
   // masked here so the data bus reads 0 outside the response cycle.
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_valid ? hold : '0;

endmodule
